// File: rtl/dm_cache_ctrl.sv
// Control FSM for a direct-mapped, write-back, write-allocate cache.
// Drives the external tag/data arrays and sequences victim write-back and line refill.
module dm_cache_ctrl #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned INDEX_W = 10,
  parameter int unsigned LINE_W  = 128,
  parameter int unsigned WORD_W  = 32
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic                                          cpu_req_valid,
  input  logic                                          cpu_req_rw,
  input  logic [ADDR_W-1:0]                             cpu_req_addr,
  input  logic [WORD_W-1:0]                             cpu_req_data,
  output logic                                          cpu_res_ready,
  output logic [WORD_W-1:0]                             cpu_res_data,
  output logic [INDEX_W-1:0]                            arr_index,
  output logic                                          tag_we,
  output logic                                          data_we,
  output logic [ADDR_W-INDEX_W-$clog2(LINE_W/8)+1:0]    tag_wdata,
  input  logic [ADDR_W-INDEX_W-$clog2(LINE_W/8)+1:0]    tag_rdata,
  output logic [LINE_W-1:0]                             data_wdata,
  input  logic [LINE_W-1:0]                             data_rdata,
  output logic                                          mem_req_valid,
  output logic                                          mem_req_rw,
  output logic [ADDR_W-1:0]                             mem_req_addr,
  output logic [LINE_W-1:0]                             mem_req_data,
  input  logic                                          mem_data_ready,
  input  logic [LINE_W-1:0]                             mem_data,
  output logic [15:0]                                   hit_count,
  output logic [15:0]                                   miss_count
);
  localparam int unsigned OFF_W  = $clog2(LINE_W/8);
  localparam int unsigned BSEL_W = $clog2(WORD_W/8);
  localparam int unsigned WSEL_W = $clog2(LINE_W/WORD_W);
  localparam int unsigned NWORDS = LINE_W/WORD_W;
  localparam int unsigned TAG_W  = ADDR_W-INDEX_W-OFF_W;
  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  typedef struct packed {
    logic             valid;
    logic             dirty;
    logic [TAG_W-1:0] tag;
  } tag_entry_t;

  typedef enum logic [1:0] {IDLE, COMPARE, WRITE_BACK, ALLOCATE} state_t;

  state_t              state, next_state;
  logic                req_rw;
  logic [TAG_W-1:0]    req_tag;
  logic [INDEX_W-1:0]  req_index;
  logic [WSEL_W-1:0]   req_wsel;
  logic [WORD_W-1:0]   req_data;
  logic [TAG_W-1:0]    victim_tag;
  logic                replay;
  tag_entry_t          rd_entry;
  logic                hit;
  logic [WORD_W-1:0]   rd_word;
  logic [LINE_W-1:0]   merged_line;
  logic                unused_addr_bits;

  assign rd_entry         = tag_entry_t'(tag_rdata);
  assign hit              = rd_entry.valid && (rd_entry.tag == req_tag);
  assign unused_addr_bits = ^cpu_req_addr[BSEL_W-1:0];

  // Selected word of the current line, and the line with the store word merged in
  always_comb begin
    rd_word     = '0;
    merged_line = data_rdata;
    for (int unsigned w = 0; w < NWORDS; w++) begin
      if (req_wsel == WSEL_W'(w)) begin
        rd_word                         = data_rdata[w*WORD_W +: WORD_W];
        merged_line[w*WORD_W +: WORD_W] = req_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:       if (cpu_req_valid) next_state = COMPARE;
      COMPARE: begin
        if (hit)                                  next_state = IDLE;
        else if (rd_entry.valid && rd_entry.dirty) next_state = WRITE_BACK;
        else                                      next_state = ALLOCATE;
      end
      WRITE_BACK: if (mem_data_ready) next_state = ALLOCATE;
      ALLOCATE:   if (mem_data_ready) next_state = COMPARE;
      default:    next_state = IDLE;
    endcase
  end

  always_comb begin
    cpu_res_ready = 1'b0;
    cpu_res_data  = '0;
    arr_index     = '0;
    tag_we        = 1'b0;
    data_we       = 1'b0;
    tag_wdata     = '0;
    data_wdata    = '0;
    mem_req_valid = 1'b0;
    mem_req_rw    = 1'b0;
    mem_req_addr  = '0;
    mem_req_data  = '0;
    unique case (state)
      IDLE: ;
      COMPARE: begin
        arr_index = req_index;
        if (hit) begin
          cpu_res_ready = 1'b1;
          if (req_rw) begin
            data_we    = 1'b1;
            data_wdata = merged_line;
            tag_we     = 1'b1;
            tag_wdata  = {1'b1, 1'b1, req_tag};
          end else begin
            cpu_res_data = rd_word;
          end
        end
      end
      // Array contents at this index are untouched here, so data_rdata stays stable
      WRITE_BACK: begin
        arr_index     = req_index;
        mem_req_valid = 1'b1;
        mem_req_rw    = 1'b1;
        mem_req_addr  = {victim_tag, req_index, OFF_W'(0)};
        mem_req_data  = data_rdata;
      end
      ALLOCATE: begin
        arr_index     = req_index;
        mem_req_valid = 1'b1;
        mem_req_addr  = {req_tag, req_index, OFF_W'(0)};
        if (mem_data_ready) begin
          data_we    = 1'b1;
          data_wdata = mem_data;
          tag_we     = 1'b1;
          tag_wdata  = {1'b1, 1'b0, req_tag};
        end
      end
      default: ;
    endcase
  end

  // Request latch, victim tag, replay flag and saturating counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_rw     <= 1'b0;
      req_tag    <= '0;
      req_index  <= '0;
      req_wsel   <= '0;
      req_data   <= '0;
      victim_tag <= '0;
      replay     <= 1'b0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (state == IDLE && cpu_req_valid) begin
        req_rw    <= cpu_req_rw;
        req_tag   <= cpu_req_addr[ADDR_W-1 -: TAG_W];
        req_index <= cpu_req_addr[OFF_W +: INDEX_W];
        req_wsel  <= cpu_req_addr[BSEL_W +: WSEL_W];
        req_data  <= cpu_req_data;
        replay    <= 1'b0;
      end
      if (state == COMPARE) begin
        if (hit) begin
          if (!replay && hit_count != CNT_MAX) hit_count <= hit_count + 16'd1;
        end else begin
          if (miss_count != CNT_MAX) miss_count <= miss_count + 16'd1;
          if (rd_entry.valid && rd_entry.dirty) victim_tag <= rd_entry.tag;
        end
      end
      if (state == ALLOCATE && mem_data_ready) replay <= 1'b1;
    end
  end
endmodule

// File: tb/tb_dm_cache_ctrl.sv
// Directed bench for dm_cache_ctrl: models the tag/data arrays and memory port,
// and checks hits, clean/dirty misses, mid-transaction reset and counter saturation.
module tb_dm_cache_ctrl;
  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned INDEX_W = 10;
  localparam int unsigned LINE_W  = 128;
  localparam int unsigned WORD_W  = 32;
  localparam int unsigned TAG_W   = 18;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                cpu_req_valid = 1'b0;
  logic                cpu_req_rw = 1'b0;
  logic [ADDR_W-1:0]   cpu_req_addr = '0;
  logic [WORD_W-1:0]   cpu_req_data = '0;
  logic                cpu_res_ready;
  logic [WORD_W-1:0]   cpu_res_data;
  logic [INDEX_W-1:0]  arr_index;
  logic                tag_we, data_we;
  logic [TAG_W+1:0]    tag_wdata, tag_rdata;
  logic [LINE_W-1:0]   data_wdata, data_rdata;
  logic                mem_req_valid, mem_req_rw;
  logic [ADDR_W-1:0]   mem_req_addr;
  logic [LINE_W-1:0]   mem_req_data;
  logic                mem_data_ready = 1'b0;
  logic [LINE_W-1:0]   mem_data = '0;
  logic [15:0]         hit_count, miss_count;

  logic [TAG_W+1:0]    tag_mem  [1024];
  logic [LINE_W-1:0]   data_mem [1024];
  logic                clr_tags = 1'b1;
  int                  cyc = 0;
  int                  t0 = 0;
  int                  n_pass = 0;
  int                  n_checks = 0;

  always #5 clk = ~clk;

  dm_cache_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req_valid(cpu_req_valid), .cpu_req_rw(cpu_req_rw),
    .cpu_req_addr(cpu_req_addr), .cpu_req_data(cpu_req_data),
    .cpu_res_ready(cpu_res_ready), .cpu_res_data(cpu_res_data),
    .arr_index(arr_index), .tag_we(tag_we), .data_we(data_we),
    .tag_wdata(tag_wdata), .tag_rdata(tag_rdata),
    .data_wdata(data_wdata), .data_rdata(data_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_rw(mem_req_rw),
    .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data),
    .mem_data_ready(mem_data_ready), .mem_data(mem_data),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (clr_tags) for (int i = 0; i < 1024; i++) tag_mem[i] <= '0;
    else if (tag_we) tag_mem[arr_index] <= tag_wdata;
    if (data_we) data_mem[arr_index] <= data_wdata;
  end

  assign tag_rdata  = tag_mem[arr_index];
  assign data_rdata = data_mem[arr_index];

  task automatic check(input string name, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
  endtask

  // Present a request for one IDLE cycle; returns at the COMPARE-cycle negedge
  task automatic start_req(input logic rw, input logic [31:0] addr, input logic [31:0] data);
    cpu_req_valid = 1'b1;
    cpu_req_rw    = rw;
    cpu_req_addr  = addr;
    cpu_req_data  = data;
    t0 = cyc;
    @(negedge clk);
    cpu_req_valid = 1'b0;
    cpu_req_rw    = 1'b0;
    cpu_req_addr  = '0;
    cpu_req_data  = '0;
  endtask

  task automatic wait_res(input string name, input int exp_lat, input logic chk_data,
                          input logic [31:0] exp_data);
    int n = 0;
    while (!cpu_res_ready && n < 40) begin @(negedge clk); n++; end
    check({name, " latency"}, LINE_W'(cyc - t0), LINE_W'(exp_lat));
    if (chk_data) check({name, " data"}, LINE_W'(cpu_res_data), LINE_W'(exp_data));
    @(negedge clk);
  endtask

  task automatic serve_mem(input string name, input logic exp_rw, input logic [31:0] exp_addr,
                           input logic chk_wdata, input logic [LINE_W-1:0] exp_wdata,
                           input int delay, input logic [LINE_W-1:0] rdata);
    int  n = 0;
    logic stable = 1'b1;
    while (!mem_req_valid && n < 20) begin @(negedge clk); n++; end
    check({name, " valid"}, LINE_W'(mem_req_valid), LINE_W'(1'b1));
    check({name, " rw"},    LINE_W'(mem_req_rw),    LINE_W'(exp_rw));
    check({name, " addr"},  LINE_W'(mem_req_addr),  LINE_W'(exp_addr));
    if (chk_wdata) check({name, " wdata"}, mem_req_data, exp_wdata);
    for (int i = 0; i < delay; i++) begin
      @(negedge clk);
      if (mem_req_valid !== 1'b1 || mem_req_rw !== exp_rw || mem_req_addr !== exp_addr ||
          (chk_wdata && mem_req_data !== exp_wdata)) stable = 1'b0;
    end
    if (delay > 0) check({name, " held stable"}, LINE_W'(stable), LINE_W'(1'b1));
    mem_data       = rdata;
    mem_data_ready = 1'b1;
    @(negedge clk);
    mem_data_ready = 1'b0;
    mem_data       = '0;
  endtask

  initial begin
    logic [LINE_W-1:0] line_a;
    logic [LINE_W-1:0] line_b;
    logic [LINE_W-1:0] line_c;
    logic [LINE_W-1:0] line_mod;
    line_a   = {32'h1, 32'h2, 32'h3, 32'h0};
    line_b   = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
    line_c   = {32'hB3, 32'hB2, 32'hB1, 32'hB0};
    line_mod = {32'h1, 32'h2, 32'h3, 32'hDEADBEEF};

    @(negedge clk);
    @(negedge clk);
    check("reset mem_req_valid", LINE_W'(mem_req_valid), '0);
    check("reset res_ready",     LINE_W'(cpu_res_ready), '0);
    check("reset hit_count",     LINE_W'(hit_count), '0);
    check("reset miss_count",    LINE_W'(miss_count), '0);
    clr_tags = 1'b0;
    rst_n    = 1'b1;
    @(negedge clk);

    // Cold read: clean miss, same-cycle refill
    start_req(1'b0, 32'h0000_1234, '0);
    check("t1 no res in compare miss", LINE_W'(cpu_res_ready), '0);
    serve_mem("t1 alloc", 1'b0, 32'h0000_1230, 1'b0, '0, 0, line_a);
    wait_res("t1", 3, 1'b1, 32'h3);
    check("t1 miss_count", LINE_W'(miss_count), LINE_W'(16'd1));
    check("t1 hit_count",  LINE_W'(hit_count),  LINE_W'(16'd0));
    check("t1 tag entry",  LINE_W'(tag_mem[10'h123]), LINE_W'(20'h80000));

    // Read hit
    start_req(1'b0, 32'h0000_1238, '0);
    wait_res("t2", 1, 1'b1, 32'h2);
    check("t2 hit_count", LINE_W'(hit_count), LINE_W'(16'd1));

    // Write hit, then read back
    start_req(1'b1, 32'h0000_1230, 32'hDEAD_BEEF);
    check("t3 tag_we",     LINE_W'(tag_we),    LINE_W'(1'b1));
    check("t3 tag_wdata",  LINE_W'(tag_wdata), LINE_W'(20'hC0000));
    check("t3 data_we",    LINE_W'(data_we),   LINE_W'(1'b1));
    check("t3 data_wdata", data_wdata, line_mod);
    wait_res("t3 wr", 1, 1'b0, '0);
    start_req(1'b0, 32'h0000_1230, '0);
    wait_res("t3 rd", 1, 1'b1, 32'hDEAD_BEEF);
    check("t3 hit_count", LINE_W'(hit_count), LINE_W'(16'd3));

    // Dirty miss with 5-cycle memory delays on both phases
    start_req(1'b0, 32'h0010_1230, '0);
    serve_mem("t4 wb",    1'b1, 32'h0000_1230, 1'b1, line_mod, 5, '0);
    serve_mem("t4 alloc", 1'b0, 32'h0010_1230, 1'b0, '0, 5, line_b);
    wait_res("t4", 14, 1'b1, 32'hA0);
    check("t4 miss_count", LINE_W'(miss_count), LINE_W'(16'd2));
    check("t4 hit_count",  LINE_W'(hit_count),  LINE_W'(16'd3));
    check("t4 tag entry",  LINE_W'(tag_mem[10'h123]), LINE_W'(20'h80040));

    // Reset asserted during ALLOCATE
    start_req(1'b0, 32'h0020_1230, '0);
    @(negedge clk);
    check("t5 in alloc", LINE_W'(mem_req_valid), LINE_W'(1'b1));
    rst_n = 1'b0;
    #1;
    check("t5 rst mem_req_valid", LINE_W'(mem_req_valid), '0);
    check("t5 rst mem_req_addr",  LINE_W'(mem_req_addr), '0);
    check("t5 rst arr_index",     LINE_W'(arr_index), '0);
    check("t5 rst hit_count",     LINE_W'(hit_count), '0);
    check("t5 rst miss_count",    LINE_W'(miss_count), '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("t5 array untouched", LINE_W'(tag_mem[10'h123]), LINE_W'(20'h80040));
    start_req(1'b0, 32'h0020_1230, '0);
    serve_mem("t5 alloc", 1'b0, 32'h0020_1230, 1'b0, '0, 0, line_c);
    wait_res("t5", 3, 1'b1, 32'hB0);
    check("t5 miss_count", LINE_W'(miss_count), LINE_W'(16'd1));

    // Hit counter saturation
    force dut.hit_count = 16'hFFFE;
    #1;
    release dut.hit_count;
    for (int k = 0; k < 3; k++) begin
      start_req(1'b0, 32'h0020_1234, '0);
      wait_res("t6", 1, 1'b1, 32'hB1);
      check("t6 hit_count", LINE_W'(hit_count), LINE_W'(16'hFFFF));
    end
    check("t6 miss_count", LINE_W'(miss_count), LINE_W'(16'd1));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
